// File: rtl/msk_lbox_fwd_seq.sv
// Masked forward Clyde-128 L-box: a d-share state of four 32-bit rows is processed as two
// row pairs, one pair per cycle, through a single share-wise lbox core.
module msk_lbox_fwd_seq #(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [128*d-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*d-1:0] out_state
);
    localparam int RW = 32 * d;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAIR0 = 2'd1,
        PAIR1 = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           fsm_q, fsm_d;
    logic [128*d-1:0] st_q, st_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [RW-1:0]    core_x_s, core_y_s, core_a_s, core_b_s;

    // Rotating by n bit positions moves whole d-share groups, so shares never mix.
    function automatic logic [RW-1:0] rotr(input logic [RW-1:0] w, input int n);
        rotr = (w >> (n * d)) | (w << ((32 - n) * d));
    endfunction

    function automatic logic [2*RW-1:0] lbox(input logic [RW-1:0] x, input logic [RW-1:0] y);
        logic [RW-1:0] a, b, c, e;
        a = x ^ rotr(x, 12);
        b = y ^ rotr(y, 12);
        a = a ^ rotr(a, 3);
        b = b ^ rotr(b, 3);
        a = a ^ rotr(x, 17);
        b = b ^ rotr(y, 17);
        c = a ^ rotr(a, 31);
        e = b ^ rotr(b, 31);
        a = a ^ rotr(e, 26);
        b = b ^ rotr(c, 25);
        a = a ^ rotr(c, 15);
        b = b ^ rotr(e, 15);
        lbox = {b, a};
    endfunction

    // Core input mux: rows 2,3 in PAIR1, rows 0,1 otherwise.
    always_comb begin
        if (fsm_q == PAIR1) begin
            core_x_s = st_q[3*RW-1:2*RW];
            core_y_s = st_q[4*RW-1:3*RW];
        end else begin
            core_x_s = st_q[RW-1:0];
            core_y_s = st_q[2*RW-1:RW];
        end
        {core_b_s, core_a_s} = lbox(core_x_s, core_y_s);
    end

    // Next-state and state-register update; only the active row pair is written.
    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    fsm_d = PAIR0;
                end else begin
                    fsm_d = IDLE;
                end
            end
            PAIR0: begin
                st_d[2*RW-1:0] = {core_b_s, core_a_s};
                fsm_d          = PAIR1;
            end
            PAIR1: begin
                st_d[4*RW-1:2*RW] = {core_b_s, core_a_s};
                fsm_d             = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State, data and registered handshake flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm_q       <= IDLE;
            st_q        <= {(128*d){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            in_ready_q  <= (fsm_d == IDLE);
            out_valid_q <= (fsm_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = st_q;

endmodule

// File: tb/tb_msk_lbox_fwd_seq.sv
// Directed bench for msk_lbox_fwd_seq with d=2: known vector, share invariance, inverse
// round trip, backpressure and asynchronous reset in mid-computation.
module tb_msk_lbox_fwd_seq;
    localparam int D = 2;
    localparam int W = 128 * D;

    localparam logic [127:0] KV     = {32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    localparam logic [127:0] KV_EXP = {32'h1BC0_01B0, 32'h2014_406E, 32'h1BC0_01B0, 32'h2014_406E};

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_state;

    int checks = 0;
    int errors = 0;

    msk_lbox_fwd_seq #(.d(D)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] share_pack(input logic [127:0] v, input logic [127:0] m);
        logic [W-1:0] s;
        s = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                s[r*64 + i*2]     = v[r*32 + i] ^ m[r*32 + i];
                s[r*64 + i*2 + 1] = m[r*32 + i];
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] recombine(input logic [W-1:0] s);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                v[r*32 + i] = s[r*64 + i*2] ^ s[r*64 + i*2 + 1];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] w, input int n);
        return (w >> n) | (w << (32 - n));
    endfunction

    // Inverse lbox on unmasked words; returns {y', x'}.
    function automatic logic [63:0] lbox_inv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, c, e;
        a = x ^ rotr32(x, 25);
        b = y ^ rotr32(y, 25);
        c = x ^ rotr32(a, 31);
        e = y ^ rotr32(b, 31);
        c = c ^ rotr32(a, 20);
        e = e ^ rotr32(b, 20);
        a = c ^ rotr32(c, 31);
        b = e ^ rotr32(e, 31);
        c = c ^ rotr32(b, 26);
        e = e ^ rotr32(a, 25);
        a = a ^ rotr32(c, 17);
        b = b ^ rotr32(e, 17);
        return {rotr32(b, 16), rotr32(a, 16)};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the engine idle; returns the DONE-cycle output.
    task automatic run_op(input string tag, input logic [W-1:0] st, output logic [W-1:0] res);
        int lat;
        check_val({tag, " in_ready"}, W'(in_ready), W'(1'b1));
        in_state = st;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = {rand128(), rand128()};
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, " latency"}, W'(lat), W'(3));
        res       = out_state;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, " idle {ov,ir}"}, W'({out_valid, in_ready}), W'(2'b01));
    endtask

    initial begin
        logic [W-1:0]   res;
        logic [W-1:0]   held;
        logic [127:0]   v;
        logic [127:0]   r;
        logic [127:0]   inv;

        nrst      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        repeat (2) @(negedge clk);
        check_val("rst in_ready", W'(in_ready), W'(1'b1));
        check_val("rst out_valid", W'(out_valid), W'(1'b0));
        check_val("rst out_state", out_state, '0);
        nrst = 1'b1;
        @(negedge clk);

        run_op("zero", '0, res);
        check_val("zero out", res, '0);

        run_op("kv", share_pack(KV, 128'h0), res);
        check_val("kv raw", res, share_pack(KV_EXP, 128'h0));

        for (int k = 0; k < 100; k++) begin
            run_op("mask", share_pack(KV, rand128()), res);
            check_val("mask recomb", W'(recombine(res)), W'(KV_EXP));
        end

        for (int k = 0; k < 8; k++) begin
            v = rand128();
            run_op("rt", share_pack(v, rand128()), res);
            r = recombine(res);
            inv[63:0]   = lbox_inv(r[31:0], r[63:32]);
            inv[127:64] = lbox_inv(r[95:64], r[127:96]);
            check_val("roundtrip", W'(inv), W'(v));
        end

        in_state = share_pack(KV, rand128());
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("bp out_valid", W'(out_valid), W'(1'b1));
        held = out_state;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_state = {rand128(), rand128()};
            @(negedge clk);
            check_val("bp hold ov", W'(out_valid), W'(1'b1));
            check_val("bp hold ir", W'(in_ready), W'(1'b0));
            check_val("bp hold st", out_state, held);
            check_val("bp hold val", W'(recombine(out_state)), W'(KV_EXP));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp release {ov,ir}", W'({out_valid, in_ready}), W'(2'b01));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("bp single {ov,ir}", W'({out_valid, in_ready}), W'(2'b01));

        in_state = share_pack(KV, rand128());
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        nrst     = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("mid-rst out_valid", W'(out_valid), W'(1'b0));
        check_val("mid-rst in_ready", W'(in_ready), W'(1'b1));
        check_val("mid-rst out_state", out_state, '0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        run_op("post-rst", share_pack(KV, rand128()), res);
        check_val("post-rst recomb", W'(recombine(res)), W'(KV_EXP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
